// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit feeding the WB_MUL write-back path.
//   A one-cycle start pulse launches a fixed 33-cycle sequence:
//   32 iteration cycles, then one fix-up cycle that applies the sign and
//   selects the result. A DONE cycle follows before the unit is idle again.
//
//   Optional feature macro: RV32M_DIV_EN
//     defined   -> restoring divider, DIV/DIVU/REM/REMU fully supported
//     undefined -> no divide datapath; ops 1xx keep the same timing and
//                  complete with out = 0
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-low reset
//   start  in   1   launch request, accepted only in IDLE without kill
//   op     in   3   RV32M funct3
//   a      in  32   rs1 (multiplicand / dividend)
//   b      in  32   rs2 (multiplier / divisor)
//   kill   in   1   abort the in-flight operation
//   busy   out  1   operation in flight
//   valid  out  1   one-cycle completion pulse
//   out    out 32   result, held until the next completion or reset

module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        valid,
  output logic [31:0] out
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic        busy_reg;
  logic        valid_reg;
  logic [31:0] out_reg;

  // Captured operation
  logic [2:0]  op_reg;
  logic        neg_reg;       // sign of product / quotient
  logic [31:0] mcand_reg;     // multiplicand magnitude
  logic [63:0] prod_reg;      // {accumulator, remaining multiplier bits}

  // Launch decode
  logic        accept;
  logic        a_signed, b_signed;
  logic        sa, sb;
  logic [31:0] a_mag, b_mag;

  assign accept   = (state_reg == IDLE) && start && !kill;
  // MULH, MULHSU, DIV, REM treat a as signed; MULHSU leaves b unsigned.
  assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign sa       = a_signed & a[31];
  assign sb       = b_signed & b[31];
  assign a_mag    = sa ? (~a + 32'd1) : a;
  assign b_mag    = sb ? (~b + 32'd1) : b;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole register right.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, prod_reg[63:32]} + (prod_reg[0] ? {1'b0, mcand_reg} : 33'd0);

  logic [63:0] prod_fix;
  logic [31:0] mul_result;
  assign prod_fix   = neg_reg ? (~prod_reg + 64'd1) : prod_reg;
  assign mul_result = (op_reg[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];

  logic [31:0] result;

`ifdef RV32M_DIV_EN
  logic        rem_neg_reg;   // remainder takes the dividend's sign
  logic        div_zero_reg;
  logic        ovf_reg;
  logic [31:0] dvsr_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;       // dividend bits shift out as quotient bits shift in

  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  assign div_shift = {rem_reg, quo_reg[31]};
  assign div_diff  = div_shift - {1'b0, dvsr_reg};
  // A borrow into bit 32 means the trial subtraction went negative.
  assign div_ge    = ~div_diff[32];

  logic [31:0] q_fix, r_fix, div_result;
  assign q_fix = neg_reg ? (~quo_reg + 32'd1) : quo_reg;
  // Divide by zero leaves |a| in the remainder, so restoring its sign gives a.
  assign r_fix = rem_neg_reg ? (~rem_reg + 32'd1) : rem_reg;

  always_comb begin
    div_result = 32'd0;
    if (op_reg[1]) begin
      div_result = ovf_reg ? 32'd0 : r_fix;
    end else if (div_zero_reg) begin
      div_result = 32'hFFFF_FFFF;
    end else if (ovf_reg) begin
      div_result = 32'h8000_0000;
    end else begin
      div_result = q_fix;
    end
  end

  assign result = op_reg[2] ? div_result : mul_result;

  always_ff @(posedge clk) begin
    if (accept) begin
      rem_neg_reg  <= sa;
      div_zero_reg <= (b == 32'd0);
      ovf_reg      <= op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      dvsr_reg     <= b_mag;
      rem_reg      <= 32'd0;
      quo_reg      <= a_mag;
    end else if (state_reg == ITER) begin
      rem_reg <= div_ge ? div_diff[31:0] : div_shift[31:0];
      quo_reg <= {quo_reg[30:0], div_ge};
    end
  end
`else
  assign result = op_reg[2] ? 32'd0 : mul_result;
`endif

  // Next-state logic; kill wins over everything outside IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start && !kill) state_next = ITER;
      ITER: begin
        if (kill)                  state_next = IDLE;
        else if (cnt_reg == 6'd31) state_next = FIX;
      end
      FIX:  state_next = kill ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 6'd0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      out_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      valid_reg <= (state_reg == FIX) && !kill;
      if ((state_reg == FIX) && !kill) out_reg <= result;
      if (accept)                      cnt_reg <= 6'd0;
      else if (state_reg == ITER)      cnt_reg <= cnt_reg + 6'd1;
    end
  end

  // Operand capture and multiply iteration; contents only matter once
  // a launch has loaded them, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_reg    <= op;
      neg_reg   <= sa ^ sb;
      mcand_reg <= a_mag;
      prod_reg  <= {32'd0, b_mag};
    end else if (state_reg == ITER) begin
      prod_reg <= {mul_sum, prod_reg[31:1]};
    end
  end

  assign busy  = busy_reg;
  assign valid = valid_reg;
  assign out   = out_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed bench for mul_div_unit: reset state, multiply variants,
//   divide variants and special cases, kill, ignored start and reset
//   in the middle of an operation. Divide expectations collapse to 0
//   when RV32M_DIV_EN is not defined.

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic        valid;
  logic [31:0] dut_out;

  int n_cmp = 0;
  int n_err = 0;
  int vcount = 0;
  int v_base = 0;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .kill  (kill),
    .busy  (busy),
    .valid (valid),
    .out   (dut_out)
  );

  always #5 clk = ~clk;

  // Count valid pulses away from the active edge.
  always @(negedge clk) begin
    if (valid === 1'b1) vcount <= vcount + 1;
  end

  function automatic logic [31:0] dx(input logic [31:0] v);
`ifdef RV32M_DIV_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse; returns #1 after E0.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    v_base = vcount;
    check("busy_e0", {31'd0, busy}, 32'd1);
  endtask

  // Wait out the rest of an operation; 'elapsed' edges after E0 already passed.
  task automatic finish_op(input int elapsed, input logic [31:0] exp, input string tag);
    repeat (32 - elapsed) @(posedge clk);
    #1;
    check({tag, "_novalid_e32"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy_e32"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_valid_e33"}, {31'd0, valid}, 32'd1);
    check({tag, "_out"}, dut_out, exp);
    @(posedge clk);
    #1;
    check({tag, "_valid_e34"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy_e34"}, {31'd0, busy}, 32'd0);
    check({tag, "_pulses"}, vcount, v_base + 1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag);
    launch(o, x, y);
    finish_op(0, exp, tag);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    kill  = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_out", dut_out, 32'd0);
    reset = 1'b1;

    // MUL 7 * -3
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");

    // Kill mid-operation: sampled at E11
    launch(3'b000, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("kill_nopulse", vcount, v_base);
    check("kill_out_kept", dut_out, 32'hFFFF_FFEB);

    // Start together with kill in IDLE is ignored
    op = 3'b000; a = 32'd1; b = 32'd1;
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle", {31'd0, busy}, 32'd0);

    // Start at E5 with different operands is ignored: MULHU 2^16*2^16 -> 1
    launch(3'b011, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    finish_op(5, 32'h0000_0001, "ign_start");

    // High products
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'b001, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, "mulh_neg");

    // Signed divide
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, dx(32'hFFFF_FFFD), "div");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, dx(32'hFFFF_FFFF), "rem");
    run_op(3'b101, 32'd100, 32'd7, dx(32'd14), "divu");
    run_op(3'b111, 32'd100, 32'd7, dx(32'd2), "remu");

    // Special cases
    run_op(3'b101, 32'd5, 32'd0, dx(32'hFFFF_FFFF), "divu_zero");
    run_op(3'b111, 32'd5, 32'd0, dx(32'd5), "remu_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, dx(32'h8000_0000), "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, dx(32'd0), "rem_ovf");

    // Fresh multiply to get a non-zero out before the reset test
    run_op(3'b000, 32'h1234_5678, 32'd1, 32'h1234_5678, "mul_one");

    // Reset at E20 of a DIV
    launch(3'b100, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_out", dut_out, 32'd0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_nopulse", vcount, v_base);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit producing the `mul` operand of the write-back multiplexer (WB_MUL path). It accepts a one-cycle start pulse from the decode/execute stage with two 32-bit operands and a funct3 opcode. It computes the result over a fixed 33-cycle sequence with shift-add multiplication or restoring division, then presents the 32-bit result with a one-cycle valid pulse. The core stalls on `busy`.

## Interface
- No parameters; operand width fixed at 32 (`word`).
- `clk  in  1`: single clock; all state updates on rising edge.
- `reset  in  1`: synchronous, active-low reset.
- `start  in  1`: launch request; sampled only in IDLE.
- `op  in  3`: RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a  in  32`: rs1 operand (multiplicand / dividend).
- `b  in  32`: rs2 operand (multiplier / divisor).
- `kill  in  1`: abort the in-flight operation (interrupt/flush).
- `busy  out  1`: operation in flight; the core holds the pipeline.
- `valid  out  1`: one-cycle pulse; `out` holds the result.
- `out  out  32`: result. Holds its value until the next completion or reset.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE, `start`=1 and `kill`=0:
  - Latch `op`.
  - Latch operand magnitudes. Signed ops take |a| and/or |b|. MULHSU treats only `a` as signed.
  - Latch the result sign: product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
  - Clear the 6-bit counter and go to ITER.
- ITER runs 32 cycles:
  - Multiply: 64-bit accumulator, shift-add one multiplier bit per cycle, LSB first.
  - Divide: restoring algorithm. Each cycle shifts the 33-bit partial remainder left by one, trial-subtracts the divisor, and sets one quotient bit MSB first.
  - Counter reaches 31 → FIX.
- FIX, one cycle:
  - Apply two's-complement sign correction.
  - Select the output half: MUL low 32 bits. MULH/MULHSU/MULHU high 32 bits. DIV/DIVU quotient. REM/REMU remainder.
  - Register the result into `out`. Set `valid`. Go to DONE.
- DONE, one cycle: `valid` deasserts, state → IDLE. `start` is not accepted in DONE.
- Special cases resolved in FIX. Latency stays fixed.
  - Divisor 0: quotient = 0xFFFFFFFF. Remainder = `a`.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- `start` while not IDLE: ignored, no queuing.
- `kill` in any non-IDLE state: state → IDLE at the next edge.
  - `valid` is not raised.
  - `out` is unchanged.
  - `kill` during FIX suppresses the pending `valid`/`out` update.
- `kill` and `start` both high in IDLE: `start` is ignored.
- Operands are captured at start. Changes to `a`/`b`/`op` afterwards have no effect.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `busy`=0, `valid`=0, `out`=0x00000000, counter 0. Takes priority over all inputs, including mid-operation.
- `start` sampled at edge E0:
  - `busy`=1 from E0 through E34.
  - ITER spans E1..E32. FIX is evaluated at E33.
  - `valid`=1 and the new `out` appear between E33 and E34.
  - `busy`=0 after E34.
  - Earliest next accepted `start` is at E35.
- `busy` is registered (state != IDLE). `valid` is registered, high exactly one cycle per completed operation.

## Configuration
- `RV32M_DIV_EN` defined: full RV32M; division datapath (33-bit subtractor, quotient register, divide special cases) compiled in.
- Not defined: divide datapath is removed.
  - Ops 1xx still follow the same state sequence and 33-cycle latency.
  - They complete with `out`=0x00000000.
  - Multiply ops are unaffected.

## Test plan
- Reset and MUL: hold `reset`=0 for 2 cycles, check `busy`/`valid`/`out`=0. Start MUL a=7, b=0xFFFFFFFD → `valid` at E33 with `out`=0xFFFFFFEB, `busy` drops after E34.
- High products:
  - MULH a=b=0x80000000 → 0x40000000.
  - MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same → 0.
  - Latency 33 in all four.
  - Without `RV32M_DIV_EN`: all four → 0x00000000 at E33.
- Kill and ignored start:
  - Start MUL, pulse `kill` at E10 → `busy`=0 after E11, no `valid`, `out` keeps its previous value.
  - Pulse `start` with different operands at E5 of a running op → original result only.
  - Fresh start afterwards completes normally.
- Reset mid-operation: `reset`=0 at E20 of a DIV → `busy`/`valid`/`out`=0 after that edge, no `valid` later.
